// File: rtl/sat_accumulator_pkg.sv
// ----------------------------------------------------------------------------
// sat_accumulator_pkg
//   Shared definitions for the saturating frame accumulator.
//   - acc_state_t : frame FSM encoding (ACCUM collects beats, HOLD presents
//                   the finished result until the consumer takes it).
//   - DEF_BITWIDTH / DEF_COUNT_W : default sample and beat-counter widths.
// ----------------------------------------------------------------------------
package sat_accumulator_pkg;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } acc_state_t;

  localparam int DEF_BITWIDTH = 32;
  localparam int DEF_COUNT_W  = 8;

endpackage

// File: rtl/capped_adder.sv
// ----------------------------------------------------------------------------
// capped_adder
//   Combinational signed adder that clamps to the two's-complement rails
//   instead of wrapping.
// Ports
//   a, b : signed operands, BITWIDTH bits
//   sum  : a + b clamped to [-2^(BITWIDTH-1), 2^(BITWIDTH-1)-1]
// ----------------------------------------------------------------------------
module capped_adder #(
  parameter int BITWIDTH = 32
) (
  input  logic signed [BITWIDTH-1:0] a,
  input  logic signed [BITWIDTH-1:0] b,
  output logic signed [BITWIDTH-1:0] sum
);

  localparam logic signed [BITWIDTH-1:0] SAT_MAX = {1'b0, {(BITWIDTH-1){1'b1}}};
  localparam logic signed [BITWIDTH-1:0] SAT_MIN = {1'b1, {(BITWIDTH-1){1'b0}}};

  // One guard bit is enough: overflow shows up as the guard bit disagreeing
  // with the top result bit, and the guard bit gives the true sign.
  function automatic logic signed [BITWIDTH-1:0] clamp_add(
    input logic signed [BITWIDTH-1:0] x,
    input logic signed [BITWIDTH-1:0] y
  );
    logic signed [BITWIDTH:0] wide;
    wide = {x[BITWIDTH-1], x} + {y[BITWIDTH-1], y};
    if (wide[BITWIDTH] != wide[BITWIDTH-1])
      clamp_add = wide[BITWIDTH] ? SAT_MIN : SAT_MAX;
    else
      clamp_add = wide[BITWIDTH-1:0];
  endfunction

  assign sum = clamp_add(a, b);

endmodule

// File: rtl/sat_accumulator.sv
// ----------------------------------------------------------------------------
// sat_accumulator
//   Streaming signed saturating accumulator. Sums a frame of samples (frame
//   ends on in_last) with clamp-to-rail arithmetic and presents one result
//   word with the beat count and a sticky clip flag.
// Ports
//   clk, rst   : clock, synchronous active-high reset
//   in_valid   : sample valid          in_ready  : sample accepted this cycle
//   in_data    : signed sample          in_last   : final beat of the frame
//   out_valid  : result valid           out_ready : consumer accepts result
//   out_sum    : saturated frame sum    out_count : beats in frame (saturating)
//   out_sat    : some add in the frame clipped to a rail
// ----------------------------------------------------------------------------
module sat_accumulator
  import sat_accumulator_pkg::*;
#(
  parameter int BITWIDTH = DEF_BITWIDTH,
  parameter int COUNT_W  = DEF_COUNT_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [BITWIDTH-1:0] in_data,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [BITWIDTH-1:0] out_sum,
  output logic        [COUNT_W-1:0]  out_count,
  output logic                       out_sat
);

  acc_state_t                 state;
  logic signed [BITWIDTH-1:0] acc;
  logic        [COUNT_W-1:0]  cnt;
  logic                       sat;

  logic signed [BITWIDTH-1:0] sum_capped;
  logic signed [BITWIDTH-1:0] raw_sum;
  logic                       clip;
  logic        [COUNT_W-1:0]  cnt_n;
  logic                       sat_n;
  logic                       unused_raw_low;

  capped_adder #(
    .BITWIDTH(BITWIDTH)
  ) u_adder (
    .a  (acc),
    .b  (in_data),
    .sum(sum_capped)
  );

  // Clip is taken from the wrapped sum: like-signed operands whose wrapped
  // result flips sign have overflowed, so the adder output sits on a rail.
  assign raw_sum        = acc + in_data;
  assign unused_raw_low = ^raw_sum[BITWIDTH-2:0];
  assign clip           = (acc[BITWIDTH-1] == in_data[BITWIDTH-1]) &&
                          (raw_sum[BITWIDTH-1] != acc[BITWIDTH-1]);

  assign cnt_n = (&cnt) ? cnt : cnt + COUNT_W'(1);
  assign sat_n = sat | clip;

  // Handshake flags decode directly from the state register.
  assign in_ready  = (state == ST_ACCUM);
  assign out_valid = (state == ST_HOLD);

  // ---- frame accumulation / result register stage ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_ACCUM;
      acc       <= '0;
      cnt       <= '0;
      sat       <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_sat   <= 1'b0;
    end else begin
      unique case (state)
        ST_ACCUM: begin
          if (in_valid) begin
            if (in_last) begin
              out_sum   <= sum_capped;
              out_count <= cnt_n;
              out_sat   <= sat_n;
              acc       <= '0;
              cnt       <= '0;
              sat       <= 1'b0;
              state     <= ST_HOLD;
            end else begin
              acc <= sum_capped;
              cnt <= cnt_n;
              sat <= sat_n;
            end
          end
        end
        ST_HOLD: begin
          if (out_ready)
            state <= ST_ACCUM;
        end
        default: state <= ST_ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_sat_accumulator.sv
module tb_sat_accumulator;

  localparam int BW = 8;
  localparam int CW = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [BW-1:0] in_data;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [BW-1:0] out_sum;
  logic        [CW-1:0] out_count;
  logic                 out_sat;

  int total = 0;
  int bad   = 0;
  int frame_q[$];
  bit gaps = 1'b0;

  sat_accumulator #(.BITWIDTH(BW), .COUNT_W(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_count(out_count),
    .out_sat  (out_sat)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference: integer sum clamped after every beat, flag set whenever the
  // clamp engages, count capped at the counter's all-ones value.
  task automatic model(output int esum, output int ecnt, output int esat);
    int acc;
    acc  = 0;
    esat = 0;
    foreach (frame_q[i]) begin
      acc = acc + frame_q[i];
      if (acc > 127) begin
        acc  = 127;
        esat = 1;
      end else if (acc < -128) begin
        acc  = -128;
        esat = 1;
      end
    end
    esum = acc;
    ecnt = (frame_q.size() > 15) ? 15 : frame_q.size();
  endtask

  // Sends frame_q, checks the result, waits `hold` cycles with out_ready low,
  // then completes the handshake and checks the return to ACCUM.
  task automatic run_frame(input int hold);
    int esum, ecnt, esat;
    model(esum, ecnt, esat);
    out_ready = (hold == 0);
    foreach (frame_q[i]) begin
      while (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        in_data  = BW'($urandom);
        in_last  = $urandom_range(0, 1) != 0;
        step();
      end
      chk("in_ready_accum", 32'(in_ready), 1);
      in_valid = 1'b1;
      in_data  = BW'(frame_q[i]);
      in_last  = (i == frame_q.size() - 1);
      step();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("out_valid", 32'(out_valid), 1);
    chk("in_ready_hold", 32'(in_ready), 0);
    chk("out_sum", out_sum, esum);
    chk("out_count", 32'(out_count), ecnt);
    chk("out_sat", 32'(out_sat), esat);
    for (int h = 0; h < hold; h++) begin
      step();
      chk("hold_valid", 32'(out_valid), 1);
      chk("hold_in_ready", 32'(in_ready), 0);
      chk("hold_sum", out_sum, esum);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("post_valid", 32'(out_valid), 0);
    chk("post_in_ready", 32'(in_ready), 1);
    chk("post_sum", out_sum, esum);
    chk("post_count", 32'(out_count), ecnt);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    step();
    rst = 1'b0;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_sum", out_sum, 0);
    chk("rst_count", 32'(out_count), 0);
    chk("rst_sat", 32'(out_sat), 0);

    frame_q = '{10, 20, -5};          run_frame(0);
    frame_q = '{100, 100};            run_frame(0);
    frame_q = '{-100, -100, -100};    run_frame(0);
    frame_q = '{100, 100, -50};       run_frame(0);
    frame_q = '{1};                   run_frame(0);
    frame_q = '{-128};                run_frame(0);
    frame_q = '{127, 1, -1};          run_frame(0);
    frame_q = '{3, 4};                run_frame(5);

    frame_q = '{};
    for (int i = 0; i < 20; i++) frame_q.push_back(1);
    run_frame(0);

    // Reset mid-frame: three beats in, then rst with a live beat presented.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 8'sd40;
      in_last  = 1'b0;
      step();
    end
    in_last = 1'b1;
    rst     = 1'b1;
    step();
    chk("midrst_valid", 32'(out_valid), 0);
    chk("midrst_sum", out_sum, 0);
    rst      = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    step();
    chk("midrst_idle_valid", 32'(out_valid), 0);
    frame_q = '{5};                   run_frame(0);

    // Reset while a result is pending discards it.
    frame_q = '{7, 8};
    in_valid = 1'b1; in_data = 8'sd7; in_last = 1'b0; step();
    in_data = 8'sd8; in_last = 1'b1; step();
    in_valid = 1'b0; in_last = 1'b0;
    chk("pend_valid", 32'(out_valid), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("pendrst_valid", 32'(out_valid), 0);
    chk("pendrst_count", 32'(out_count), 0);

    gaps = 1'b1;
    for (int f = 0; f < 40; f++) begin
      int n;
      n = $urandom_range(1, 20);
      frame_q = '{};
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 2) == 0)
          frame_q.push_back($urandom_range(0, 255) - 128);
        else
          frame_q.push_back($urandom_range(0, 80) - 40);
      end
      run_frame($urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
